// File: rtl/hazard_ctrl_gen_if.sv
// Pipeline hazard controller bus: D-stage decode fields in, stall/forward/stage controls out.
// slave is the controller side, master is the pipeline (or bench) side.
interface hazard_ctrl_gen_if #(parameter int REG_AW = 5);
  logic [4:0]        op_in;
  logic [2:0]        f3_in;
  logic              f7_in;
  logic              f7m_in;
  logic [REG_AW-1:0] rs1_index_in;
  logic [REG_AW-1:0] rs2_index_in;
  logic [REG_AW-1:0] rd_index_in;
  logic              branch_taken;
  logic              md_done;
  logic              dm_ready;
  logic              F_stall;
  logic              jb;
  logic              D_rs1_data_sel;
  logic              D_rs2_data_sel;
  logic [1:0]        E_rs1_data_sel;
  logic [1:0]        E_rs2_data_sel;
  logic              E_alu_op1_sel;
  logic              E_alu_op2_sel;
  logic              E_jb_op_sel;
  logic [4:0]        E_opcode_out;
  logic [2:0]        E_func3_out;
  logic              E_func7_out;
  logic              E_md_out;
  logic              md_start;
  logic [3:0]        M_dm_w_en;
  logic              M_dm_req;
  logic              W_wb_en;
  logic              W_wb_data_sel;
  logic [REG_AW-1:0] W_rd_index;
  logic [2:0]        W_f3_out;

  modport slave (
    input  op_in, f3_in, f7_in, f7m_in, rs1_index_in, rs2_index_in, rd_index_in,
           branch_taken, md_done, dm_ready,
    output F_stall, jb, D_rs1_data_sel, D_rs2_data_sel, E_rs1_data_sel, E_rs2_data_sel,
           E_alu_op1_sel, E_alu_op2_sel, E_jb_op_sel, E_opcode_out, E_func3_out,
           E_func7_out, E_md_out, md_start, M_dm_w_en, M_dm_req, W_wb_en,
           W_wb_data_sel, W_rd_index, W_f3_out
  );
  modport master (
    output op_in, f3_in, f7_in, f7m_in, rs1_index_in, rs2_index_in, rd_index_in,
           branch_taken, md_done, dm_ready,
    input  F_stall, jb, D_rs1_data_sel, D_rs2_data_sel, E_rs1_data_sel, E_rs2_data_sel,
           E_alu_op1_sel, E_alu_op2_sel, E_jb_op_sel, E_opcode_out, E_func3_out,
           E_func7_out, E_md_out, md_start, M_dm_w_en, M_dm_req, W_wb_en,
           W_wb_data_sel, W_rd_index, W_f3_out
  );
endinterface

// File: rtl/hazard_ctrl_gen.sv
// 5-stage pipeline hazard controller: E/M/W control registers, stall/flush FSM,
// bypass selects and per-stage decoded controls.
module hazard_ctrl_gen #(
  parameter int REG_AW     = 5,
  parameter int M_EXT      = 1,
  parameter int DM_WAIT_EN = 1
) (
  input logic clk,
  input logic rst,
  hazard_ctrl_gen_if.slave bus
);
  localparam logic [4:0] OP_R  = 5'b01100, OP_II = 5'b00100, OP_IJ = 5'b11001,
                         OP_IL = 5'b00000, OP_S  = 5'b01000, OP_B  = 5'b11000,
                         OP_UL = 5'b01101, OP_UA = 5'b00101, OP_J  = 5'b11011;

  typedef struct packed {
    logic              vld;
    logic [4:0]        op;
    logic [2:0]        f3;
    logic [REG_AW-1:0] rd;
  } stg_t;

  typedef struct packed {
    stg_t              s;
    logic              f7;
    logic              f7m;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
  } est_t;

  typedef enum logic [1:0] {RUN, MD_WAIT, DM_WAIT} state_t;

  localparam stg_t BUB   = '{1'b0, OP_II, 3'd0, {REG_AW{1'b0}}};
  localparam est_t E_BUB = '{BUB, 1'b0, 1'b0, {REG_AW{1'b0}}, {REG_AW{1'b0}}};

  function automatic logic use1(input logic [4:0] op);
    return op inside {OP_R, OP_II, OP_IL, OP_S, OP_B, OP_IJ};
  endfunction
  function automatic logic use2(input logic [4:0] op);
    return op inside {OP_R, OP_S, OP_B};
  endfunction
  function automatic logic wrd(input logic [4:0] op);
    return op inside {OP_R, OP_II, OP_IJ, OP_IL, OP_UL, OP_UA, OP_J};
  endfunction

  state_t state, state_nx;
  est_t   e_q, e_nx, d_in;
  stg_t   m_q, m_nx, w_q, w_nx;
  logic   kill_q, kill_nx;

  logic dm_rdy, md_dn, m_req, freeze, e_md, md_wait, jb_raw, jb, load_use, f_stall;
  logic m_wr, w_wr, e_u1, e_u2;

  assign dm_rdy  = (DM_WAIT_EN != 0) ? bus.dm_ready : 1'b1;
  assign md_dn   = (M_EXT != 0) & bus.md_done;
  assign m_req   = m_q.vld & (m_q.op == OP_IL | m_q.op == OP_S);
  assign freeze  = m_req & ~dm_rdy;
  assign e_md    = e_q.s.vld & (e_q.s.op == OP_R) & e_q.f7m & (M_EXT != 0);
  assign md_wait = ~freeze & e_md & ~md_dn;
  assign jb_raw  = bus.branch_taken | (e_q.s.vld & (e_q.s.op == OP_IJ | e_q.s.op == OP_J));
  assign jb      = jb_raw & ~freeze & ~md_wait & (state != MD_WAIT);

  // Killed D slots never raise load-use; they enter E as bubbles anyway.
  assign load_use = ~kill_q & e_q.s.vld & (e_q.s.op == OP_IL) & (|e_q.s.rd) &
                    ((use1(bus.op_in) & (bus.rs1_index_in == e_q.s.rd)) |
                     (use2(bus.op_in) & (bus.rs2_index_in == e_q.s.rd)));

  always_comb begin
    d_in       = E_BUB;
    d_in.s.vld = 1'b1;
    d_in.s.op  = bus.op_in;
    d_in.s.f3  = bus.f3_in;
    d_in.s.rd  = bus.rd_index_in;
    d_in.f7    = bus.f7_in;
    d_in.f7m   = bus.f7m_in;
    d_in.rs1   = bus.rs1_index_in;
    d_in.rs2   = bus.rs2_index_in;
  end

  always_comb begin
    e_nx     = e_q;
    m_nx     = m_q;
    w_nx     = w_q;
    kill_nx  = kill_q;
    state_nx = RUN;
    f_stall  = 1'b0;
    if (freeze) begin
      state_nx = DM_WAIT;
      f_stall  = 1'b1;
    end else if (md_wait) begin
      state_nx = MD_WAIT;
      f_stall  = 1'b1;
      m_nx     = BUB;
      w_nx     = m_q;
    end else begin
      w_nx = m_q;
      m_nx = e_q.s;
      if (jb) begin
        e_nx    = E_BUB;
        kill_nx = 1'b1;
      end else if (load_use) begin
        e_nx    = E_BUB;
        f_stall = 1'b1;
      end else begin
        e_nx    = kill_q ? E_BUB : d_in;
        kill_nx = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      e_q    <= E_BUB;
      m_q    <= BUB;
      w_q    <= BUB;
      kill_q <= 1'b0;
    end else begin
      state  <= state_nx;
      e_q    <= e_nx;
      m_q    <= m_nx;
      w_q    <= w_nx;
      kill_q <= kill_nx;
    end
  end

  assign m_wr = m_q.vld & wrd(m_q.op);
  assign w_wr = w_q.vld & wrd(w_q.op);
  assign e_u1 = e_q.s.vld & use1(e_q.s.op);
  assign e_u2 = e_q.s.vld & use2(e_q.s.op);

  // M result is newer than W, so it wins when both match.
  assign bus.E_rs1_data_sel = (e_u1 & m_wr & (|e_q.rs1) & (e_q.rs1 == m_q.rd)) ? 2'd1 :
                              (e_u1 & w_wr & (|e_q.rs1) & (e_q.rs1 == w_q.rd)) ? 2'd0 : 2'd2;
  assign bus.E_rs2_data_sel = (e_u2 & m_wr & (|e_q.rs2) & (e_q.rs2 == m_q.rd)) ? 2'd1 :
                              (e_u2 & w_wr & (|e_q.rs2) & (e_q.rs2 == w_q.rd)) ? 2'd0 : 2'd2;
  assign bus.D_rs1_data_sel = use1(bus.op_in) & w_wr & (|bus.rs1_index_in) &
                              (bus.rs1_index_in == w_q.rd);
  assign bus.D_rs2_data_sel = use2(bus.op_in) & w_wr & (|bus.rs2_index_in) &
                              (bus.rs2_index_in == w_q.rd);

  logic [2:0] opsel;
  always_comb begin
    opsel = 3'b000;
    if (e_q.s.vld) begin
      case (e_q.s.op)
        OP_II, OP_IL, OP_S, OP_UL: opsel = 3'b010;
        OP_IJ:                     opsel = 3'b100;
        OP_B:                      opsel = 3'b001;
        OP_UA:                     opsel = 3'b110;
        OP_J:                      opsel = 3'b101;
        default:                   opsel = 3'b000;
      endcase
    end
  end
  assign {bus.E_alu_op1_sel, bus.E_alu_op2_sel, bus.E_jb_op_sel} = opsel;

  logic [3:0] wen;
  always_comb begin
    wen = 4'b0000;
    if (m_q.vld && m_q.op == OP_S) begin
      case (m_q.f3)
        3'b000:  wen = 4'b0001;
        3'b001:  wen = 4'b0011;
        3'b010:  wen = 4'b1111;
        default: wen = 4'b0000;
      endcase
    end
  end

  assign bus.F_stall       = f_stall;
  assign bus.jb            = jb;
  assign bus.md_start      = ~freeze & e_md & (state != MD_WAIT);
  assign bus.E_opcode_out  = e_q.s.op;
  assign bus.E_func3_out   = e_q.s.f3;
  assign bus.E_func7_out   = e_q.f7;
  assign bus.E_md_out      = e_md;
  assign bus.M_dm_w_en     = wen;
  assign bus.M_dm_req      = m_req;
  assign bus.W_wb_en       = w_wr & ~freeze;
  assign bus.W_wb_data_sel = w_q.vld & (w_q.op == OP_IL);
  assign bus.W_rd_index    = w_q.rd;
  assign bus.W_f3_out      = w_q.f3;
endmodule

// File: tb/tb_hazard_ctrl_gen.sv
// Directed bench for hazard_ctrl_gen: forwarding, load-use, branch flush,
// mul/div wait, memory freeze and reset behaviour against hand-computed values.
module tb_hazard_ctrl_gen;
  localparam logic [4:0] R = 5'b01100, II = 5'b00100, IJ = 5'b11001, IL = 5'b00000,
                         S = 5'b01000, B = 5'b11000, UL = 5'b01101, UA = 5'b00101,
                         J = 5'b11011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  hazard_ctrl_gen_if #(.REG_AW(5)) bus ();
  hazard_ctrl_gen #(.REG_AW(5), .M_EXT(1), .DM_WAIT_EN(1)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setd(input logic [4:0] op, input logic [2:0] f3, input logic f7,
                      input logic f7m, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd);
    bus.op_in = op; bus.f3_in = f3; bus.f7_in = f7; bus.f7m_in = f7m;
    bus.rs1_index_in = rs1; bus.rs2_index_in = rs2; bus.rd_index_in = rd;
  endtask

  // Untaken beq x0,x0: writes nothing, reads only x0.
  task automatic nop();
    setd(B, 3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; nop(); tick(); rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.branch_taken = 1'b0; bus.md_done = 1'b0; bus.dm_ready = 1'b1;
    nop(); rst = 1'b1; tick(); tick(); rst = 1'b0; #1;
    total++; if ({bus.F_stall, bus.jb, bus.md_start, bus.M_dm_req, bus.W_wb_en} !== 5'b0)
      begin bad++; $display("FAIL reset_ctl got %b want 00000",
        {bus.F_stall, bus.jb, bus.md_start, bus.M_dm_req, bus.W_wb_en}); end
    total++; if (bus.M_dm_w_en !== 4'b0000)
      begin bad++; $display("FAIL reset_wen got %b want 0000", bus.M_dm_w_en); end
    total++; if ({bus.E_rs1_data_sel, bus.E_rs2_data_sel} !== 4'b1010)
      begin bad++; $display("FAIL reset_esel got %b want 1010",
        {bus.E_rs1_data_sel, bus.E_rs2_data_sel}); end
    total++; if ({bus.D_rs1_data_sel, bus.D_rs2_data_sel} !== 2'b00)
      begin bad++; $display("FAIL reset_dsel got %b want 00",
        {bus.D_rs1_data_sel, bus.D_rs2_data_sel}); end
    total++; if ({bus.E_opcode_out, bus.E_md_out} !== {II, 1'b0})
      begin bad++; $display("FAIL reset_eop got %b want %b0",
        {bus.E_opcode_out, bus.E_md_out}, II); end
  endtask

  task automatic test_forward();
    do_reset();
    setd(R, 3'd0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3); tick();          // add x3,x1,x2
    setd(R, 3'd0, 1'b1, 1'b0, 5'd3, 5'd3, 5'd4); #1;              // sub x4,x3,x3
    total++; if ({bus.E_rs1_data_sel, bus.E_rs2_data_sel} !== 4'b1010)
      begin bad++; $display("FAIL fwd_add_nofwd got %b want 1010",
        {bus.E_rs1_data_sel, bus.E_rs2_data_sel}); end
    tick();
    setd(R, 3'd6, 1'b0, 1'b0, 5'd3, 5'd4, 5'd5); #1;              // or x5,x3,x4
    total++; if ({bus.E_rs1_data_sel, bus.E_rs2_data_sel} !== 4'b0101)
      begin bad++; $display("FAIL fwd_sub_m got %b want 0101",
        {bus.E_rs1_data_sel, bus.E_rs2_data_sel}); end
    total++; if (bus.E_func7_out !== 1'b1)
      begin bad++; $display("FAIL fwd_sub_f7 got %b want 1", bus.E_func7_out); end
    tick();
    setd(B, 3'd0, 1'b0, 1'b0, 5'd3, 5'd0, 5'd0); #1;              // beq x3,x0
    total++; if ({bus.E_rs1_data_sel, bus.E_rs2_data_sel} !== 4'b0001)
      begin bad++; $display("FAIL fwd_or_wm got %b want 0001",
        {bus.E_rs1_data_sel, bus.E_rs2_data_sel}); end
    total++; if ({bus.D_rs1_data_sel, bus.D_rs2_data_sel} !== 2'b10)
      begin bad++; $display("FAIL fwd_dsel got %b want 10",
        {bus.D_rs1_data_sel, bus.D_rs2_data_sel}); end
    total++; if ({bus.W_wb_en, bus.W_rd_index} !== {1'b1, 5'd3})
      begin bad++; $display("FAIL fwd_w_add got %b want 100011",
        {bus.W_wb_en, bus.W_rd_index}); end
    tick(); nop(); #1;
    total++; if ({bus.E_rs1_data_sel, bus.E_rs2_data_sel, bus.E_jb_op_sel, bus.jb} !== 6'b101010)
      begin bad++; $display("FAIL fwd_beq got %b want 101010",
        {bus.E_rs1_data_sel, bus.E_rs2_data_sel, bus.E_jb_op_sel, bus.jb}); end
  endtask

  task automatic test_load_use();
    do_reset();
    setd(IL, 3'd2, 1'b0, 1'b0, 5'd1, 5'd0, 5'd5); tick();         // lw x5
    setd(II, 3'd0, 1'b0, 1'b0, 5'd5, 5'd0, 5'd6); #1;             // addi x6,x5,1
    total++; if ({bus.F_stall, bus.jb} !== 2'b10)
      begin bad++; $display("FAIL lu_stall got %b want 10", {bus.F_stall, bus.jb}); end
    tick(); #1;
    total++; if ({bus.F_stall, bus.E_alu_op2_sel, bus.M_dm_req, bus.E_opcode_out} !== {3'b001, II})
      begin bad++; $display("FAIL lu_bubble got %b want 001%b",
        {bus.F_stall, bus.E_alu_op2_sel, bus.M_dm_req, bus.E_opcode_out}, II); end
    tick(); nop(); #1;
    total++; if ({bus.E_rs1_data_sel, bus.F_stall} !== 3'b000)
      begin bad++; $display("FAIL lu_wbyp got %b want 000",
        {bus.E_rs1_data_sel, bus.F_stall}); end
    total++; if ({bus.W_wb_en, bus.W_wb_data_sel, bus.W_rd_index, bus.W_f3_out} !== {2'b11, 5'd5, 3'd2})
      begin bad++; $display("FAIL lu_w_load got %b want 1100101010",
        {bus.W_wb_en, bus.W_wb_data_sel, bus.W_rd_index, bus.W_f3_out}); end
    tick(); #1;
    total++; if ({bus.W_wb_en, bus.M_dm_req} !== 2'b00)
      begin bad++; $display("FAIL lu_after got %b want 00", {bus.W_wb_en, bus.M_dm_req}); end
  endtask

  task automatic test_branch();
    do_reset();
    setd(B, 3'd0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0); tick();          // beq x1,x2
    setd(II, 3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd7); bus.branch_taken = 1'b1; #1;
    total++; if ({bus.jb, bus.F_stall} !== 2'b10)
      begin bad++; $display("FAIL br_jb got %b want 10", {bus.jb, bus.F_stall}); end
    tick(); bus.branch_taken = 1'b0;
    setd(II, 3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd8); #1;
    total++; if ({bus.jb, bus.E_alu_op2_sel} !== 2'b00)
      begin bad++; $display("FAIL br_bub1 got %b want 00", {bus.jb, bus.E_alu_op2_sel}); end
    tick();
    setd(II, 3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd9); #1;
    total++; if ({bus.E_alu_op2_sel, bus.W_wb_en} !== 2'b00)
      begin bad++; $display("FAIL br_bub2 got %b want 00", {bus.E_alu_op2_sel, bus.W_wb_en}); end
    tick(); nop(); #1;
    total++; if ({bus.E_alu_op2_sel, bus.W_wb_en} !== 2'b10)
      begin bad++; $display("FAIL br_good_e got %b want 10", {bus.E_alu_op2_sel, bus.W_wb_en}); end
    tick(); #1;
    total++; if (bus.W_wb_en !== 1'b0)
      begin bad++; $display("FAIL br_kill_w got %b want 0", bus.W_wb_en); end
    tick(); #1;
    total++; if ({bus.W_wb_en, bus.W_rd_index} !== {1'b1, 5'd9})
      begin bad++; $display("FAIL br_good_w got %b want 101001", {bus.W_wb_en, bus.W_rd_index}); end
  endtask

  logic [4:0] ops  [9] = '{R, II, IJ, IL, S, B, UL, UA, J};
  logic [3:0] msel [9] = '{4'b0000, 4'b0100, 4'b1001, 4'b0100, 4'b0100,
                           4'b0010, 4'b0100, 4'b1100, 4'b1011};

  task automatic test_opsel();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      setd(ops[i], 3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0); tick(); nop(); #1;
      total++;
      if ({bus.E_opcode_out, bus.E_alu_op1_sel, bus.E_alu_op2_sel, bus.E_jb_op_sel, bus.jb} !==
          {ops[i], msel[i]})
        begin bad++; $display("FAIL opsel_%0d got %b want %b", i,
          {bus.E_opcode_out, bus.E_alu_op1_sel, bus.E_alu_op2_sel, bus.E_jb_op_sel, bus.jb},
          {ops[i], msel[i]}); end
      tick(); tick();
    end
  endtask

  logic [2:0] wf3 [4] = '{3'b000, 3'b001, 3'b010, 3'b011};
  logic [3:0] wex [4] = '{4'b0001, 4'b0011, 4'b1111, 4'b0000};

  task automatic test_wen();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      setd(S, wf3[i], 1'b0, 1'b0, 5'd1, 5'd2, 5'd0); tick(); nop(); tick(); #1;
      total++; if ({bus.M_dm_req, bus.M_dm_w_en} !== {1'b1, wex[i]})
        begin bad++; $display("FAIL wen_f3_%0d got %b want 1%b", i,
          {bus.M_dm_req, bus.M_dm_w_en}, wex[i]); end
      tick(); tick();
    end
  endtask

  task automatic test_muldiv();
    do_reset();
    setd(R, 3'd0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd10); tick();         // mul x10
    setd(II, 3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd12); #1;
    total++; if ({bus.md_start, bus.F_stall, bus.E_md_out} !== 3'b111)
      begin bad++; $display("FAIL md_start got %b want 111",
        {bus.md_start, bus.F_stall, bus.E_md_out}); end
    for (int c = 0; c < 2; c++) begin
      tick(); #1;
      total++; if ({bus.md_start, bus.F_stall, bus.jb, bus.W_wb_en} !== 4'b0100)
        begin bad++; $display("FAIL md_wait_%0d got %b want 0100", c,
          {bus.md_start, bus.F_stall, bus.jb, bus.W_wb_en}); end
    end
    tick(); bus.md_done = 1'b1; #1;
    total++; if ({bus.md_start, bus.F_stall, bus.E_md_out} !== 3'b001)
      begin bad++; $display("FAIL md_done got %b want 001",
        {bus.md_start, bus.F_stall, bus.E_md_out}); end
    tick(); bus.md_done = 1'b0; nop(); #1;
    total++; if ({bus.E_md_out, bus.W_wb_en, bus.E_opcode_out} !== {2'b00, II})
      begin bad++; $display("FAIL md_adv got %b want 00%b",
        {bus.E_md_out, bus.W_wb_en, bus.E_opcode_out}, II); end
    tick(); #1;
    total++; if ({bus.W_wb_en, bus.W_rd_index} !== {1'b1, 5'd10})
      begin bad++; $display("FAIL md_w_mul got %b want 101010", {bus.W_wb_en, bus.W_rd_index}); end
    tick(); #1;
    total++; if ({bus.W_wb_en, bus.W_rd_index} !== {1'b1, 5'd12})
      begin bad++; $display("FAIL md_w_once got %b want 101100", {bus.W_wb_en, bus.W_rd_index}); end
    // md_done already high in the start cycle: no wait cycle at all
    setd(R, 3'd0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd15); tick(); nop(); bus.md_done = 1'b1; #1;
    total++; if ({bus.md_start, bus.F_stall} !== 2'b10)
      begin bad++; $display("FAIL md_fast got %b want 10", {bus.md_start, bus.F_stall}); end
    tick(); bus.md_done = 1'b0; #1;
    total++; if ({bus.md_start, bus.E_md_out, bus.F_stall} !== 3'b000)
      begin bad++; $display("FAIL md_fast_adv got %b want 000",
        {bus.md_start, bus.E_md_out, bus.F_stall}); end
  endtask

  task automatic test_freeze();
    do_reset();
    setd(II, 3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd14); tick();
    setd(S, 3'b010, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0); tick();        // sw x2,0(x1)
    setd(II, 3'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd13); tick();
    nop(); bus.dm_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      total++; if ({bus.M_dm_req, bus.M_dm_w_en, bus.F_stall, bus.W_wb_en, bus.W_rd_index} !==
                   {7'b1111110, 5'd14})
        begin bad++; $display("FAIL frz_%0d got %b want 111111001110", c,
          {bus.M_dm_req, bus.M_dm_w_en, bus.F_stall, bus.W_wb_en, bus.W_rd_index}); end
      total++; if ({bus.E_opcode_out, bus.jb} !== {II, 1'b0})
        begin bad++; $display("FAIL frz_e_%0d got %b want %b0", c,
          {bus.E_opcode_out, bus.jb}, II); end
      tick();
    end
    bus.dm_ready = 1'b1; #1;
    total++; if ({bus.M_dm_req, bus.M_dm_w_en, bus.F_stall, bus.W_wb_en} !== 7'b1111101)
      begin bad++; $display("FAIL frz_release got %b want 1111101",
        {bus.M_dm_req, bus.M_dm_w_en, bus.F_stall, bus.W_wb_en}); end
    tick(); #1;
    total++; if ({bus.M_dm_req, bus.M_dm_w_en, bus.W_wb_en} !== 6'b000000)
      begin bad++; $display("FAIL frz_w_sw got %b want 000000",
        {bus.M_dm_req, bus.M_dm_w_en, bus.W_wb_en}); end
    tick(); #1;
    total++; if ({bus.W_wb_en, bus.W_rd_index} !== {1'b1, 5'd13})
      begin bad++; $display("FAIL frz_w_next got %b want 101101", {bus.W_wb_en, bus.W_rd_index}); end
  endtask

  task automatic test_rst_md();
    do_reset();
    setd(R, 3'd0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd10); tick();
    nop(); tick(); bus.branch_taken = 1'b1; #1;
    total++; if ({bus.jb, bus.F_stall, bus.md_start} !== 3'b010)
      begin bad++; $display("FAIL mdw_nojb got %b want 010",
        {bus.jb, bus.F_stall, bus.md_start}); end
    bus.branch_taken = 1'b0; rst = 1'b1; tick(); rst = 1'b0; #1;
    total++; if ({bus.md_start, bus.F_stall, bus.E_md_out, bus.W_wb_en, bus.M_dm_req} !== 5'b0)
      begin bad++; $display("FAIL rst_md got %b want 00000",
        {bus.md_start, bus.F_stall, bus.E_md_out, bus.W_wb_en, bus.M_dm_req}); end
    setd(R, 3'd0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd11); tick(); nop(); #1;
    total++; if (bus.md_start !== 1'b1)
      begin bad++; $display("FAIL rst_md_run got %b want 1", bus.md_start); end
    bus.md_done = 1'b1; tick(); bus.md_done = 1'b0;
  endtask

  initial begin
    bus.branch_taken = 1'b0; bus.md_done = 1'b0; bus.dm_ready = 1'b1; nop();
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_opsel();
    test_wen();
    test_muldiv();
    test_freeze();
    test_rst_md();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
